expr_eval_seq: RTL and testbench

Sequential, parametrised Verilog-expression evaluator. It applies one binary operator per transaction to operands of configurable width and signedness, following IEEE 1364-2005 width-extension and signedness rules. Where the language result would be `x`, it produces a defined value plus an explicit `y_undef` flag. It is the synthesizable reference model in the expression-equivalence flow: stimulus generators push operand pairs in, and checkers compare `y`/`y_undef` against tool outputs.

---
 rtl/expr_eval_seq.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_expr_eval_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval_seq.sv
// expr_eval_seq: sequential reference evaluator for one Verilog binary
// operator per transaction, with IEEE 1364-2005 width and sign extension.
// A result that the language would make x is reported through y_undef,
// and y is then forced to all ones.
module expr_eval_seq #(
    parameter int WA       = 4,
    parameter int WB       = 4,
    parameter int WY       = 8,
    parameter bit A_SIGNED = 1'b1,
    parameter bit B_SIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WY-1:0] y,
    output logic          y_undef
);

    // Context widths: full expression, comparison operands, shift/power base.
    localparam int W_AB  = (WA > WB) ? WA : WB;
    localparam int W     = (W_AB > WY) ? W_AB : WY;
    localparam int CW    = W_AB;
    localparam int SW    = (WA > WY) ? WA : WY;
    localparam bit SC    = A_SIGNED && B_SIGNED;
    localparam int CNT_W = $clog2(W + 1) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_POW = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ASL = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;
    localparam logic [3:0] OP_LE  = 4'd11;
    localparam logic [3:0] OP_EQ  = 4'd12;
    localparam logic [3:0] OP_NE  = 4'd13;
    localparam logic [3:0] OP_AND = 4'd14;
    localparam logic [3:0] OP_XOR = 4'd15;

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WY-1:0]    y_q;
    logic             undef_q;

    // Divider state: quotient/dividend shift register, partial remainder.
    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             div_zero_q;

    // Power state: base, running accumulator, exponent consumed MSB first.
    logic [SW-1:0]    pw_base_q;
    logic [SW-1:0]    pw_acc_q;
    logic [WB-1:0]    pw_exp_q;

    // Extended operand views.
    logic [W-1:0]         a_w;
    logic [W-1:0]         b_w;
    logic signed [CW-1:0] a_c;
    logic signed [CW-1:0] b_c;
    logic signed [SW-1:0] a_sh;
    logic [SW-1:0]        pw_base_in;

    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         a_abs;
    logic [W-1:0]         b_abs;

    logic                 lt;
    logic                 le;
    logic [WY-1:0]        imm_y;

    logic                 pw_neg_exp;
    logic [WY-1:0]        neg_y;
    logic                 neg_undef;

    logic [W:0]           rem_sh;
    logic [W:0]           diff;
    logic                 q_bit;
    logic [W-1:0]         quo_n;
    logic [W-1:0]         rem_n;
    logic [W-1:0]         q_fin;
    logic [W-1:0]         r_fin;

    logic [SW-1:0]        pw_sq;
    logic [SW-1:0]        pw_acc_n;

    logic [WY-1:0]        calc_y;
    logic                 calc_undef;

    // Operand extension: expression context is signed only when both are.
    always_comb begin
        if (SC) begin
            a_w        = W'($signed(a));
            b_w        = W'($signed(b));
            a_c        = CW'($signed(a));
            b_c        = CW'($signed(b));
            pw_base_in = SW'($signed(a));
        end else begin
            a_w        = W'(a);
            b_w        = W'(b);
            a_c        = CW'(a);
            b_c        = CW'(b);
            pw_base_in = SW'(a);
        end
        if (A_SIGNED) begin
            a_sh = SW'($signed(a));
        end else begin
            a_sh = SW'(a);
        end
    end

    // Magnitudes and signs feeding the unsigned restoring divider.
    always_comb begin
        a_neg = SC && a_w[W-1];
        b_neg = SC && b_w[W-1];
        a_abs = a_neg ? '0 - a_w : a_w;
        b_abs = b_neg ? '0 - b_w : b_w;
    end

    // Single-cycle results for every operator except divide, modulo, power.
    always_comb begin
        imm_y = '0;
        if (SC) begin
            lt = a_c < b_c;
            le = a_c <= b_c;
        end else begin
            lt = $unsigned(a_c) < $unsigned(b_c);
            le = $unsigned(a_c) <= $unsigned(b_c);
        end
        case (op)
            OP_ADD:         imm_y = WY'(a_w + b_w);
            OP_SUB:         imm_y = WY'(a_w - b_w);
            OP_MUL:         imm_y = WY'(a_w * b_w);
            OP_SHL, OP_ASL: imm_y = WY'($unsigned(a_sh) << b);
            OP_SHR:         imm_y = WY'($unsigned(a_sh) >> b);
            OP_ASR: begin
                if (A_SIGNED) begin
                    imm_y = WY'(a_sh >>> b);
                end else begin
                    imm_y = WY'($unsigned(a_sh) >> b);
                end
            end
            OP_LT:          imm_y = WY'(lt);
            OP_LE:          imm_y = WY'(le);
            OP_EQ:          imm_y = WY'(a_c == b_c);
            OP_NE:          imm_y = WY'(a_c != b_c);
            OP_AND:         imm_y = WY'(a_w & b_w);
            OP_XOR:         imm_y = WY'(a_w ^ b_w);
            default:        imm_y = '0;
        endcase
    end

    // Negative exponent: result depends only on the base, so it resolves at accept.
    always_comb begin
        pw_neg_exp = B_SIGNED && b[WB-1];
        neg_y      = '0;
        neg_undef  = 1'b0;
        if (pw_base_in == '0) begin
            neg_y     = '1;
            neg_undef = 1'b1;
        end else if (pw_base_in == SW'(1)) begin
            neg_y = WY'(1);
        end else if (SC && (pw_base_in == '1)) begin
            neg_y = b[0] ? '1 : WY'(1);
        end
    end

    // One restoring-divide step; the remainder fits W bits after each step.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[W];
        quo_n  = (quo_q << 1) | W'(q_bit);
        rem_n  = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
        q_fin  = q_neg_q ? '0 - quo_n : quo_n;
        r_fin  = r_neg_q ? '0 - rem_n : rem_n;
    end

    // One square-and-multiply step, modulo the base context width.
    always_comb begin
        pw_sq    = pw_acc_q * pw_acc_q;
        pw_acc_n = pw_exp_q[WB-1] ? pw_sq * pw_base_q : pw_sq;
    end

    // Result presented on the final CALC step.
    always_comb begin
        calc_y     = '0;
        calc_undef = 1'b0;
        if (op_q == OP_POW) begin
            calc_y = WY'(pw_acc_n);
        end else if (div_zero_q) begin
            calc_y     = '1;
            calc_undef = 1'b1;
        end else if (op_q == OP_DIV) begin
            calc_y = WY'(q_fin);
        end else begin
            calc_y = WY'(r_fin);
        end
    end

    // Transaction FSM: accept, iterate for divide/power, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            cnt        <= '0;
            y_q        <= '0;
            undef_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            pw_base_q  <= '0;
            pw_acc_q   <= '0;
            pw_exp_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        quo_q      <= a_abs;
                        rem_q      <= '0;
                        dvs_q      <= b_abs;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        div_zero_q <= (b == '0);
                        pw_base_q  <= pw_base_in;
                        pw_acc_q   <= SW'(1);
                        pw_exp_q   <= b;
                        if ((op == OP_DIV) || (op == OP_MOD)) begin
                            cnt   <= CNT_W'(W);
                            state <= S_CALC;
                        end else if ((op == OP_POW) && !pw_neg_exp) begin
                            cnt   <= CNT_W'(WB);
                            state <= S_CALC;
                        end else if (op == OP_POW) begin
                            y_q     <= neg_y;
                            undef_q <= neg_undef;
                            state   <= S_DONE;
                        end else begin
                            y_q     <= imm_y;
                            undef_q <= 1'b0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (op_q == OP_POW) begin
                        pw_acc_q <= pw_acc_n;
                        pw_exp_q <= pw_exp_q << 1;
                    end else begin
                        quo_q <= quo_n;
                        rem_q <= rem_n;
                    end
                    if (cnt == CNT_W'(1)) begin
                        y_q     <= calc_y;
                        undef_q <= calc_undef;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign y         = y_q;
    assign y_undef   = undef_q;

endmodule

// File: tb/tb_expr_eval_seq.sv
// tb_expr_eval_seq: scoreboard bench for expr_eval_seq with three
// signedness configurations (signed/signed, signed/unsigned, unsigned/signed).
module tb_expr_eval_seq;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      t_op;
    logic [3:0]      t_a;
    logic [3:0]      t_b;
    logic [2:0]      iv;
    logic [2:0]      ordy;
    logic [2:0]      ir;
    logic [2:0]      ov;
    logic [2:0]      yu;
    logic [2:0][7:0] yv;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] y;
        logic       u;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    expr_eval_seq #(.WA(4), .WB(4), .WY(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1)) u_ss (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(t_op), .a(t_a), .b(t_b),
        .out_valid(ov[0]), .out_ready(ordy[0]), .y(yv[0]), .y_undef(yu[0])
    );

    expr_eval_seq #(.WA(4), .WB(4), .WY(8), .A_SIGNED(1'b1), .B_SIGNED(1'b0)) u_su (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(t_op), .a(t_a), .b(t_b),
        .out_valid(ov[1]), .out_ready(ordy[1]), .y(yv[1]), .y_undef(yu[1])
    );

    expr_eval_seq #(.WA(4), .WB(4), .WY(8), .A_SIGNED(1'b0), .B_SIGNED(1'b1)) u_us (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .op(t_op), .a(t_a), .b(t_b),
        .out_valid(ov[2]), .out_ready(ordy[2]), .y(yv[2]), .y_undef(yu[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference for the signed 4/4 -> 8 configuration, written with 32-bit ints.
    function automatic void model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                  output logic [7:0] ey, output logic eu, output int lat);
        int sa;
        int sb;
        int sa8;
        int r;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sa8 = sa & 255;
        r   = 0;
        eu  = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = sa + sb;
            4'd1: r = sa - sb;
            4'd2: r = sa * sb;
            4'd3, 4'd4: begin
                lat = 9;
                if (sb == 0) begin
                    r  = -1;
                    eu = 1'b1;
                end else begin
                    r = (op == 4'd3) ? sa / sb : sa % sb;
                end
            end
            4'd5: begin
                if (sb < 0) begin
                    if (sa == 0) begin
                        r  = -1;
                        eu = 1'b1;
                    end else if (sa == 1) begin
                        r = 1;
                    end else if (sa == -1) begin
                        r = (sb % 2 == 0) ? 1 : -1;
                    end else begin
                        r = 0;
                    end
                end else begin
                    lat = 5;
                    r   = 1;
                    for (int i = 0; i < sb; i++) r = r * sa;
                end
            end
            4'd6, 4'd8: r = (b >= 4'd8) ? 0 : (sa8 << b);
            4'd7:       r = (b >= 4'd8) ? 0 : (sa8 >> b);
            4'd9:       r = (b >= 4'd8) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
            4'd10:      r = (sa < sb) ? 1 : 0;
            4'd11:      r = (sa <= sb) ? 1 : 0;
            4'd12:      r = (sa == sb) ? 1 : 0;
            4'd13:      r = (sa != sb) ? 1 : 0;
            4'd14:      r = sa & sb;
            default:    r = sa ^ sb;
        endcase
        ey = 8'(r);
    endfunction

    // Drive one transaction and push its expectation to the scoreboard.
    task automatic send(input int k, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ey, input logic eu, input int elat);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!ir[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_send", ir[k], 1);
        e.y   = ey;
        e.u   = eu;
        e.lat = elat;
        exp_q.push_back(e);
        t_op  = op;
        t_a   = a;
        t_b   = b;
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    // Wait for out_valid (bounded), pop the scoreboard and compare.
    task automatic collect(input int k, input string tag);
        exp_t e;
        int   lat;
        lat = 1;
        while (!ov[k] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, ov[k], 1);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_y"}, yv[k], e.y);
            check({tag, "_undef"}, yu[k], e.u);
            check({tag, "_lat"}, lat, e.lat);
        end
    endtask

    task automatic run_txn(input string tag, input int k, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] ey, input logic eu, input int elat);
        ordy[k] = 1'b1;
        send(k, op, a, b, ey, eu, elat);
        collect(k, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ey;
        logic       eu;
        int         elat;
        logic [3:0] r_op;
        logic [3:0] r_a;
        logic [3:0] r_b;

        rst  = 1'b1;
        iv   = '0;
        ordy = '1;
        t_op = '0;
        t_a  = '0;
        t_b  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", ov[0], 0);
        check("rst_y", yv[0], 8'h00);
        check("rst_undef", yu[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", ir[0], 1);
        check("rst_out_valid_after", ov[0], 0);

        // Signed 4/4 -> 8
        run_txn("add_wrap",    0, 4'd0, 4'hF, 4'h1, 8'h00, 1'b0, 1);
        run_txn("div_neg",     0, 4'd3, 4'h9, 4'h2, 8'hFD, 1'b0, 9);
        run_txn("mod_neg",     0, 4'd4, 4'h9, 4'h2, 8'hFF, 1'b0, 9);
        run_txn("div_zero",    0, 4'd3, 4'h9, 4'h0, 8'hFF, 1'b1, 9);
        run_txn("mod_zero",    0, 4'd4, 4'h5, 4'h0, 8'hFF, 1'b1, 9);
        run_txn("div_min_m1",  0, 4'd3, 4'h8, 4'hF, 8'h08, 1'b0, 9);
        run_txn("pow_pos",     0, 4'd5, 4'hE, 4'h3, 8'hF8, 1'b0, 5);
        run_txn("pow_zero_ng", 0, 4'd5, 4'h0, 4'hF, 8'hFF, 1'b1, 1);
        run_txn("pow_m1_odd",  0, 4'd5, 4'hF, 4'hD, 8'hFF, 1'b0, 1);
        run_txn("pow_m1_even", 0, 4'd5, 4'hF, 4'hE, 8'h01, 1'b0, 1);
        run_txn("pow_one_ng",  0, 4'd5, 4'h1, 4'h8, 8'h01, 1'b0, 1);
        run_txn("pow_two_ng",  0, 4'd5, 4'h2, 4'hE, 8'h00, 1'b0, 1);
        run_txn("pow_exp0",    0, 4'd5, 4'h7, 4'h0, 8'h01, 1'b0, 5);
        run_txn("shl_big",     0, 4'd6, 4'hF, 4'hF, 8'h00, 1'b0, 1);
        run_txn("asr_signed",  0, 4'd9, 4'h8, 4'h1, 8'hFC, 1'b0, 1);
        run_txn("asr_big",     0, 4'd9, 4'h8, 4'h9, 8'hFF, 1'b0, 1);
        run_txn("shr_signext", 0, 4'd7, 4'h8, 4'h1, 8'h7C, 1'b0, 1);
        run_txn("lt_signed",   0, 4'd10, 4'hF, 4'h1, 8'h01, 1'b0, 1);

        // Signed a, unsigned b: whole context unsigned
        run_txn("add_uctx",    1, 4'd0, 4'hF, 4'h1, 8'h10, 1'b0, 1);
        run_txn("lt_uctx",     1, 4'd10, 4'hF, 4'h1, 8'h00, 1'b0, 1);
        run_txn("div_uctx",    1, 4'd3, 4'h9, 4'h2, 8'h04, 1'b0, 9);
        run_txn("pow_uexp",    1, 4'd5, 4'h2, 4'hE, 8'h00, 1'b0, 5);

        // Unsigned a: arithmetic right shift degrades to logical
        run_txn("asr_unsigned", 2, 4'd9, 4'h8, 4'h1, 8'h04, 1'b0, 1);
        run_txn("lt_uctx_a",    2, 4'd10, 4'hF, 4'h1, 8'h00, 1'b0, 1);

        // Random transactions against the reference model
        for (int i = 0; i < 30; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = 4'($urandom_range(0, 15));
            r_b  = 4'($urandom_range(0, 15));
            model(r_op, r_a, r_b, ey, eu, elat);
            run_txn($sformatf("rnd%0d_op%0d_a%0h_b%0h", i, r_op, r_a, r_b), 0, r_op, r_a, r_b, ey, eu, elat);
        end

        // Back-pressure: result held, in_ready low, stray in_valid ignored
        ordy[0] = 1'b0;
        send(0, 4'd0, 4'h3, 4'h4, 8'h07, 1'b0, 1);
        collect(0, "hold");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                t_op  = 4'd1;
                t_a   = 4'hF;
                t_b   = 4'h7;
                iv[0] = 1'b1;
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("hold_y_c%0d", c), yv[0], 8'h07);
            check($sformatf("hold_in_ready_c%0d", c), ir[0], 0);
            check($sformatf("hold_out_valid_c%0d", c), ov[0], 1);
        end
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out_valid_drop", ov[0], 0);
        check("hs_in_ready_rise", ir[0], 1);
        repeat (3) @(posedge clk);
        #1;
        check("stray_not_latched", ov[0], 0);

        // Reset during a divide
        @(negedge clk);
        check("div_abort_ready", ir[0], 1);
        t_op  = 4'd3;
        t_a   = 4'h7;
        t_b   = 4'h2;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", ov[0], 0);
        check("abort_y", yv[0], 8'h00);
        check("abort_undef", yu[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", ir[0], 1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", ov[0], 0);

        run_txn("post_abort", 0, 4'd2, 4'h3, 4'hD, 8'hF7, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
